// File: rtl/sram_responder_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the off-chip data SRAM responder model and the
// controllers that talk to it: data width, default address width, default
// wait-state counts and the responder FSM state encoding.
// ---------------------------------------------------------------------------
package sram_pkg;

    localparam int SRAM_DATA_W       = 64;
    localparam int SRAM_ADDR_W       = 17;
    localparam int SRAM_READ_LATENCY = 4;
    localparam int SRAM_WRITE_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_READ_WAIT  = 3'd1,
        ST_READ_DRIVE = 3'd2,
        ST_WRITE_WAIT = 3'd3,
        ST_TURNAROUND = 3'd4
    } sram_state_e;

    // True when the wait counter, after this edge's increment, reaches limit.
    function automatic logic cnt_hits(input logic [3:0] cnt, input logic [4:0] limit);
        return (({1'b0, cnt} + 5'd1) == limit);
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// ---------------------------------------------------------------------------
// sram_responder_if
// Pin bundle between an SRAM controller (master) and the SRAM responder
// (slave). The bidirectional data bus stays a plain inout port on the
// responder so tri-state resolution happens on an ordinary net.
//   sram_w_en     master->slave  active-low write strobe, high = read
//   sram_address  master->slave  word address
//   rsp_valid     slave->master  high while the responder drives read data
//   protocol_err  slave->master  one-cycle pulse on a strobe/address violation
// ---------------------------------------------------------------------------
interface sram_responder_if
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W
);
    logic              sram_w_en;
    logic [ADDR_W-1:0] sram_address;
    logic              rsp_valid;
    logic              protocol_err;

    modport master (
        output sram_w_en,
        output sram_address,
        input  rsp_valid,
        input  protocol_err
    );

    modport slave (
        input  sram_w_en,
        input  sram_address,
        output rsp_valid,
        output protocol_err
    );
endinterface

// File: rtl/sram_responder_array.sv
// ---------------------------------------------------------------------------
// sram_array
// Single-port storage: synchronous write, asynchronous read on the same
// address port. Kept separate so an FPGA build can swap in a block-RAM
// wrapper. Contents are not reset.
//   clk      clock
//   i_we     write enable (commits i_wdata to i_addr on the rising edge)
//   i_addr   word address shared by read and write
//   i_wdata  write data
//   o_rdata  combinational read data at i_addr
// ---------------------------------------------------------------------------
module sram_array
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1 << ADDR_W) - 1];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
// Cycle-accurate responder model of the off-chip data SRAM. Reads return
// data after READ_LATENCY cycles of a stable address with the strobe high;
// writes commit after WRITE_CYCLES consecutive low cycles at a stable
// address. Short write pulses and address changes during a write are
// flagged on protocol_err and the write is dropped.
//   clk      sole clock, rising edge
//   rst      asynchronous active-low reset
//   sram_dq  bidirectional data; driven only while presenting read data
//   bus      sram_responder_if.slave (w_en, address, rsp_valid, protocol_err)
// ---------------------------------------------------------------------------
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W       = SRAM_ADDR_W,
    parameter int READ_LATENCY = SRAM_READ_LATENCY,
    parameter int WRITE_CYCLES = SRAM_WRITE_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    inout  wire  [SRAM_DATA_W-1:0] sram_dq,
    sram_responder_if.slave        bus
);

    localparam logic [4:0] RL5   = 5'(READ_LATENCY);
    localparam logic [4:0] WC5   = 5'(WRITE_CYCLES);
    localparam logic       L_ONE = (READ_LATENCY == 1);
    localparam logic       W_ONE = (WRITE_CYCLES == 1);

    sram_state_e       r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_cnt;
    logic              r_drv;
    logic              r_err;

    logic                   w_addr_same;
    logic                   w_commit;
    logic [ADDR_W-1:0]      w_arr_addr;
    logic [SRAM_DATA_W-1:0] w_rdata;

    assign w_addr_same = (bus.sram_address == r_addr);

    // Write-commit strobe for the edge about to happen. A one-cycle write
    // commits on the very edge that first samples the strobe low.
    always_comb begin
        w_commit = 1'b0;
        case (r_state)
            ST_IDLE, ST_READ_WAIT: w_commit = W_ONE & ~bus.sram_w_en;
            ST_WRITE_WAIT:         w_commit = ~bus.sram_w_en & w_addr_same & cnt_hits(r_cnt, WC5);
            default:               w_commit = 1'b0;
        endcase
    end

    // Committing edges write at the pin address (equal to r_addr when the
    // write was held stable); otherwise the port reads the latched address.
    assign w_arr_addr = w_commit ? bus.sram_address : r_addr;

    sram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (SRAM_DATA_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_commit),
        .i_addr  (w_arr_addr),
        .i_wdata (sram_dq),
        .o_rdata (w_rdata)
    );

    // Release is gated by the live strobe so the bus frees in the same cycle
    // the controller pulls sram_w_en low, before its own driver turns on.
    assign sram_dq          = (r_drv & bus.sram_w_en) ? w_rdata : {SRAM_DATA_W{1'bz}};
    assign bus.rsp_valid    = r_drv & bus.sram_w_en;
    assign bus.protocol_err = r_err;

    // Responder FSM: address latch, wait counter, drive flag, error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_cnt   <= 4'd0;
            r_drv   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_addr <= bus.sram_address;
                    r_cnt  <= 4'd1;
                    if (bus.sram_w_en) begin
                        r_state <= L_ONE ? ST_READ_DRIVE : ST_READ_WAIT;
                        r_drv   <= L_ONE;
                    end else begin
                        r_state <= W_ONE ? ST_TURNAROUND : ST_WRITE_WAIT;
                        r_drv   <= 1'b0;
                    end
                end
                ST_READ_WAIT: begin
                    if (!bus.sram_w_en) begin
                        r_addr  <= bus.sram_address;
                        r_cnt   <= 4'd1;
                        r_drv   <= 1'b0;
                        r_state <= W_ONE ? ST_TURNAROUND : ST_WRITE_WAIT;
                    end else if (!w_addr_same) begin
                        // Plain restart of the latency count, not an error.
                        r_addr  <= bus.sram_address;
                        r_cnt   <= 4'd1;
                        r_drv   <= L_ONE;
                        r_state <= L_ONE ? ST_READ_DRIVE : ST_READ_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        if (cnt_hits(r_cnt, RL5)) begin
                            r_state <= ST_READ_DRIVE;
                            r_drv   <= 1'b1;
                        end else begin
                            r_state <= ST_READ_WAIT;
                            r_drv   <= 1'b0;
                        end
                    end
                end
                ST_READ_DRIVE: begin
                    if (!bus.sram_w_en) begin
                        r_drv   <= 1'b0;
                        r_cnt   <= 4'd0;
                        r_state <= ST_TURNAROUND;
                    end else if (!w_addr_same) begin
                        r_addr  <= bus.sram_address;
                        r_cnt   <= 4'd1;
                        r_drv   <= L_ONE;
                        r_state <= L_ONE ? ST_READ_DRIVE : ST_READ_WAIT;
                    end else begin
                        r_drv   <= 1'b1;
                        r_state <= ST_READ_DRIVE;
                    end
                end
                ST_WRITE_WAIT: begin
                    r_drv <= 1'b0;
                    if (bus.sram_w_en) begin
                        // Strobe released before the minimum pulse width.
                        r_err   <= 1'b1;
                        r_cnt   <= 4'd0;
                        r_state <= ST_TURNAROUND;
                    end else if (!w_addr_same) begin
                        r_err   <= 1'b1;
                        r_addr  <= bus.sram_address;
                        r_cnt   <= 4'd1;
                        r_state <= ST_WRITE_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        // The cycle after a commit is the bus turnaround.
                        r_state <= cnt_hits(r_cnt, WC5) ? ST_TURNAROUND : ST_WRITE_WAIT;
                    end
                end
                ST_TURNAROUND: begin
                    r_drv   <= 1'b0;
                    r_cnt   <= 4'd0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_drv   <= 1'b0;
                    r_cnt   <= 4'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;
    import sram_pkg::*;

    localparam int AW = 17;
    localparam int L  = 4;
    localparam int W  = 4;

    localparam int OP_IDLE = 0;  // responder samples the next edge in IDLE
    localparam int OP_READ = 1;  // responder is presenting read data
    localparam int OP_TA   = 2;  // next edge is the bus turnaround

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    wire  [63:0] dq;
    logic        tb_drv;
    logic [63:0] tb_data;
    assign dq = tb_drv ? tb_data : {64{1'bz}};

    sram_responder_if #(.ADDR_W(AW)) sif ();
    sram_responder #(.ADDR_W(AW), .READ_LATENCY(L), .WRITE_CYCLES(W)) u_dut (
        .clk(clk), .rst(rst), .sram_dq(dq), .bus(sif.slave));

    wire  [63:0] dq_f;
    logic        tbf_drv;
    logic [63:0] tbf_data;
    assign dq_f = tbf_drv ? tbf_data : {64{1'bz}};

    sram_responder_if #(.ADDR_W(AW)) sif_f ();
    sram_responder #(.ADDR_W(AW), .READ_LATENCY(1), .WRITE_CYCLES(1)) u_fast (
        .clk(clk), .rst(rst), .sram_dq(dq_f), .bus(sif_f.slave));

    int total = 0;
    int bad   = 0;

    // Reference model: word store plus where the responder sits between ops.
    logic [63:0]   mem_m [logic [AW-1:0]];
    int            last_op;
    logic [AW-1:0] last_rd_addr;

    typedef struct {
        logic [AW-1:0] addr;
        logic [63:0]   data;
        int            wcyc;
        logic [63:0]   exp_rd;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle edges the responder spends before it starts counting this op.
    function automatic int wr_prefix();
        return (last_op == OP_READ) ? 2 : ((last_op == OP_TA) ? 1 : 0);
    endfunction
    function automatic int rd_prefix();
        return (last_op == OP_TA) ? 1 : 0;
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [63:0] d, input int n);
        int p;
        p = wr_prefix();
        sif.sram_w_en    = 1'b0;
        sif.sram_address = a;
        tb_data          = d;
        tb_drv           = 1'b1;
        #1;
        check("wr_release_valid", {63'd0, sif.rsp_valid}, 64'd0);
        check("wr_release_dq", dq, d);
        for (int e = 1; e <= p + n; e++) begin
            tick();
            check("wr_valid", {63'd0, sif.rsp_valid}, 64'd0);
            check("wr_err", {63'd0, sif.protocol_err}, 64'd0);
            check("wr_dq", dq, d);
        end
        if (n >= W) begin
            mem_m[a] = d;
            last_op  = OP_TA;
        end else begin
            sif.sram_w_en = 1'b1;
            tb_drv        = 1'b0;
            tick();
            check("short_err_pulse", {63'd0, sif.protocol_err}, 64'd1);
            tick();
            check("short_err_clear", {63'd0, sif.protocol_err}, 64'd0);
            last_op = OP_IDLE;
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a_in, input logic use_exp, input logic [63:0] exp);
        logic [AW-1:0] a;
        logic          known;
        logic [63:0]   expv;
        int            p;
        a = a_in;
        if (last_op == OP_READ && a == last_rd_addr) a = a ^ 17'd1;
        p     = rd_prefix();
        known = use_exp || mem_m.exists(a);
        expv  = use_exp ? exp : (mem_m.exists(a) ? mem_m[a] : 64'd0);
        sif.sram_w_en    = 1'b1;
        sif.sram_address = a;
        tb_drv           = 1'b0;
        for (int e = 1; e <= p + L + 1; e++) begin
            tick();
            check("rd_valid", {63'd0, sif.rsp_valid}, (e >= p + L) ? 64'd1 : 64'd0);
            check("rd_err", {63'd0, sif.protocol_err}, 64'd0);
            if (e >= p + L && known) check("rd_data", dq, expv);
        end
        last_op      = OP_READ;
        last_rd_addr = a;
    endtask

    task automatic read_partial(input logic [AW-1:0] a, input int k);
        int p;
        p = rd_prefix();
        sif.sram_w_en    = 1'b1;
        sif.sram_address = a;
        tb_drv           = 1'b0;
        for (int e = 1; e <= p + k; e++) begin
            tick();
            check("part_valid", {63'd0, sif.rsp_valid}, 64'd0);
        end
        last_op = OP_IDLE;
    endtask

    task automatic release_reset();
        rst     = 1'b1;
        last_op = OP_IDLE;
    endtask

    task automatic read_with_reset(input logic [AW-1:0] a, input int rst_at);
        sif.sram_w_en    = 1'b1;
        sif.sram_address = a;
        tb_drv           = 1'b0;
        for (int e = 1; e <= rst_at; e++) tick();
        rst = 1'b0;
        #1;
        check("rst_valid", {63'd0, sif.rsp_valid}, 64'd0);
        check("rst_err", {63'd0, sif.protocol_err}, 64'd0);
        tb_data = 64'd0;
        tb_drv  = 1'b1;
        #1;
        check("rst_bus_free", dq, 64'd0);
        tb_drv = 1'b0;
        tick();
        tick();
        release_reset();
    endtask

    vec_t          vecs [6];
    logic [AW-1:0] pool [8];

    initial begin
        vecs[0] = '{17'h00010, 64'hDEADBEEF_01234567, 4, 64'hDEADBEEF_01234567};
        vecs[1] = '{17'h1FFFF, 64'h01234567_89ABCDEF, 4, 64'h01234567_89ABCDEF};
        vecs[2] = '{17'h1FFFF, 64'hFFFF0000_FFFF0000, 3, 64'h01234567_89ABCDEF};
        vecs[3] = '{17'h00000, 64'hA5A5A5A5_A5A5A5A5, 4, 64'hA5A5A5A5_A5A5A5A5};
        vecs[4] = '{17'h00000, 64'h5A5A5A5A_5A5A5A5A, 1, 64'hA5A5A5A5_A5A5A5A5};
        vecs[5] = '{17'h00010, 64'h11112222_33334444, 4, 64'h11112222_33334444};

        rst               = 1'b0;
        sif.sram_w_en     = 1'b1;
        sif.sram_address  = 17'd0;
        tb_drv            = 1'b0;
        tb_data           = 64'd0;
        sif_f.sram_w_en    = 1'b1;
        sif_f.sram_address = 17'd0;
        tbf_drv            = 1'b0;
        tbf_data           = 64'd0;
        last_op            = OP_IDLE;
        last_rd_addr       = 17'd0;
        repeat (3) tick();
        check("reset_valid", {63'd0, sif.rsp_valid}, 64'd0);
        check("reset_err", {63'd0, sif.protocol_err}, 64'd0);
        release_reset();

        // Table of write-then-readback vectors with constant expectations.
        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].wcyc);
            do_read(vecs[i].addr, 1'b1, vecs[i].exp_rd);
        end

        // Address restart on the 2nd read cycle: no error, full latency again.
        do_write(17'h00004, 64'h44444444_44444444, W);
        do_write(17'h00008, 64'h88888888_88888888, W);
        read_partial(17'h00004, 2);
        do_read(17'h00008, 1'b1, 64'h88888888_88888888);

        // Strobe falling while data is presented: bus frees in the same cycle.
        do_write(17'h00020, 64'h20202020_20202020, W);
        do_read(17'h00020, 1'b1, 64'h20202020_20202020);
        do_write(17'h00021, 64'h21212121_21212121, W);

        // Reset at a random point of a read, then the memory is still intact.
        read_with_reset(17'h00010, $urandom_range(1, L + 1));
        do_read(17'h00010, 1'b1, 64'h11112222_33334444);

        // Randomized traffic against the word-store model.
        pool[0] = 17'h00000;
        pool[1] = 17'h00010;
        pool[2] = 17'h1FFFF;
        for (int i = 3; i < 8; i++) pool[i] = 17'($urandom_range(0, 17'h1FFFF));
        for (int i = 0; i < 60; i++) begin
            logic [AW-1:0] a;
            int            op;
            a  = pool[$urandom_range(0, 7)];
            op = $urandom_range(0, 2);
            if (op == 0) do_read(a, 1'b0, 64'd0);
            else if (op == 1) do_write(a, {$urandom, $urandom}, W);
            else do_write(a, {$urandom, $urandom}, $urandom_range(1, W - 1));
        end

        // One-cycle build: it has been presenting address 0 since reset.
        sif_f.sram_w_en    = 1'b0;
        sif_f.sram_address = 17'h00055;
        tbf_data           = 64'hCAFEF00D_12345678;
        tbf_drv            = 1'b1;
        #1;
        check("fast_release", {63'd0, sif_f.rsp_valid}, 64'd0);
        check("fast_wr_dq", dq_f, 64'hCAFEF00D_12345678);
        repeat (3) tick();
        check("fast_wr_err", {63'd0, sif_f.protocol_err}, 64'd0);
        sif_f.sram_w_en = 1'b1;
        tbf_drv         = 1'b0;
        tick();
        check("fast_ta_valid", {63'd0, sif_f.rsp_valid}, 64'd0);
        tick();
        check("fast_rd_valid", {63'd0, sif_f.rsp_valid}, 64'd1);
        check("fast_rd_data", dq_f, 64'hCAFEF00D_12345678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
